elmnt_mul_pack: RTL



---
 rtl/elmnt_mul_pack_pkg.sv | 24 ++
 rtl/elmnt_mul_pack_if.sv | 30 +++
 rtl/elmnt_mul_pack_fxp_mul_rnd_sat.sv | 40 ++++
 rtl/elmnt_mul_pack.sv | 93 +++++++++
 4 files changed

// File: rtl/elmnt_mul_pack_pkg.sv
// Shared definitions for the packed product producer.
// Holds the Q-format defaults, the FSM state encoding and the default-width
// saturation words.
`ifndef ELMNT_MUL_PACK_PKG_SV
`define ELMNT_MUL_PACK_PKG_SV
package elmnt_mul_pack_pkg;

    // Q8.24 words, 31 taps
    localparam int unsigned WIDTH_D = 32;
    localparam int unsigned FBITS_D = 24;
    localparam int unsigned N_REG_D = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Clamp values for a WIDTH_D-bit signed word
    localparam logic [WIDTH_D-1:0] SAT_MAX_D = {1'b0, {(WIDTH_D-1){1'b1}}};
    localparam logic [WIDTH_D-1:0] SAT_MIN_D = {1'b1, {(WIDTH_D-1){1'b0}}};

endpackage
`endif

// File: rtl/elmnt_mul_pack_if.sv
// Pair-in / frame-out handshake bundle of elmnt_mul_pack.
//   in_valid/in_ready/in_x/in_w/in_last : serial (sample, weight) pairs
//   out_valid/out_ready/out_multiply/out_sat : completed product frame
// master = producer of pairs and consumer of frames; slave = elmnt_mul_pack.
interface elmnt_mul_pack_if
    import elmnt_mul_pack_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_D,
    parameter int unsigned N_REG = N_REG_D
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_x;
    logic [WIDTH-1:0]       in_w;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [N_REG*WIDTH-1:0] out_multiply;
    logic                   out_sat;

    modport master (
        output in_valid, in_x, in_w, in_last, out_ready,
        input  in_ready, out_valid, out_multiply, out_sat
    );

    modport slave (
        input  in_valid, in_x, in_w, in_last, out_ready,
        output in_ready, out_valid, out_multiply, out_sat
    );
endinterface

// File: rtl/elmnt_mul_pack_fxp_mul_rnd_sat.sv
// Signed fixed-point multiply with round-half-up and saturation (combinational).
//   a, b : signed WIDTH-bit operands with FBITS fractional bits
//   y    : rounded, saturated product in the same Q format
//   sat  : product was clamped to the positive or negative limit
module fxp_mul_rnd_sat #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FBITS = 24
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic        [WIDTH-1:0] y,
    output logic                    sat
);
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic signed [PW-1:0] RND     = PW'(1) <<< (FBITS - 1);
    localparam logic signed [PW-1:0] MAX_EXT = PW'({1'b0, {(WIDTH-1){1'b1}}});
    localparam logic signed [PW-1:0] MIN_EXT = ~MAX_EXT;

    logic signed [PW-1:0] p;
    logic signed [PW-1:0] r;
    logic                 over;
    logic                 under;

    // Full-precision product; the rounding add cannot overflow 2*WIDTH bits
    always_comb begin
        p     = PW'(a) * PW'(b);
        r     = (p + RND) >>> FBITS;
        over  = (r > MAX_EXT);
        under = (r < MIN_EXT);
        sat   = over | under;
        if (over) begin
            y = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (under) begin
            y = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            y = r[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/elmnt_mul_pack.sv
// Packs a serial stream of rounded/saturated products into an N_REG-slot bus
// for the adder-tree reducer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : elmnt_mul_pack_if slave (pairs in, packed frame out)
// A frame closes on the N_REG-th pair or on in_last; unused slots stay zero so
// the downstream sum ignores them.
module elmnt_mul_pack
    import elmnt_mul_pack_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_D,
    parameter int unsigned FBITS = FBITS_D,
    parameter int unsigned N_REG = N_REG_D
) (
    input logic             clk,
    input logic             rst_n,
    elmnt_mul_pack_if.slave bus
);
    localparam int unsigned IDXW = (N_REG > 1) ? $clog2(N_REG) : 1;

    state_t                        state_q, state_d;
    logic [IDXW-1:0]               idx_q, idx_d;
    logic [N_REG-1:0][WIDTH-1:0]   slot_q, slot_d;
    logic                          sat_q, sat_d;
    logic                          in_ready_q;
    logic                          out_valid_q;
    logic [WIDTH-1:0]              prod;
    logic                          prod_sat;

    fxp_mul_rnd_sat #(
        .WIDTH (WIDTH),
        .FBITS (FBITS)
    ) u_mul (
        .a   (bus.in_x),
        .b   (bus.in_w),
        .y   (prod),
        .sat (prod_sat)
    );

    // Next-state and slot update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        slot_d  = slot_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: state_d = FILL;
            FILL: begin
                if (bus.in_valid && in_ready_q) begin
                    slot_d[idx_q] = prod;
                    sat_d         = sat_q | prod_sat;
                    if ((idx_q == IDXW'(N_REG - 1)) || bus.in_last) begin
                        state_d = HOLD;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    slot_d  = '0;
                    sat_d   = 1'b0;
                    idx_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are decoded from the next state so they are flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            slot_q      <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            slot_q      <= slot_d;
            sat_q       <= sat_d;
            in_ready_q  <= (state_d == FILL);
            out_valid_q <= (state_d == HOLD);
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_multiply = slot_q;
    assign bus.out_sat      = sat_q;
endmodule
